muldiv_unit: RTL and testbench

Multi-cycle integer multiply/divide engine for the execute stage. It takes operands from the execute pipeline register: forwarded `rs`/`rt`, plus `hi`/`lo` for accumulate ops. It produces the 64-bit `{hi,lo}` result that the execute stage writes into `dest_hi_data`/`dest_lo_data`. The execute stage's `stall`, `bubble` and `nullify` controls drive it directly: under `stall` it keeps computing, and under `bubble` it waits because its operands are not yet valid. It asserts `busy` so the pipeline controller holds execute until the result is ready.

---
 rtl/muldiv_unit_if.sv | 45 ++++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// muldiv_unit_if
//   Request/response bundle between the execute stage and the multi-cycle
//   multiply/divide engine.
//
//   master (execute stage) drives:
//      start     - valid mult/div-class instruction held in execute
//      op[2:0]   - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
//      rs, rt    - forwarded operands (dividend/multiplicand, divisor/multiplier)
//      hi_in,
//      lo_in     - current HI/LO accumulator for the accumulate ops
//      stall     - execute stage stall
//      bubble    - operands not yet forwarded
//      nullify   - flush execute
//   slave (muldiv_unit) drives:
//      busy      - combinational; execute must be held
//      done      - result valid on hi_out/lo_out
//      hi_out,
//      lo_out    - registered 64-bit result
// ----------------------------------------------------------------------------
interface muldiv_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic [31:0] hi_in;
   logic [31:0] lo_in;
   logic        stall;
   logic        bubble;
   logic        nullify;
   logic        busy;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   modport master (
      output start, op, rs, rt, hi_in, lo_in, stall, bubble, nullify,
      input  busy, done, hi_out, lo_out
   );

   modport slave (
      input  start, op, rs, rt, hi_in, lo_in, stall, bubble, nullify,
      output busy, done, hi_out, lo_out
   );
endinterface

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle integer multiply/divide engine for the execute stage.
//   Multiplies take MUL_LATENCY cycles, divides take exactly 32 cycles
//   (restoring radix-2 on operand magnitudes, sign fixed on entry to DONE).
//   The result is held in DONE until execute is no longer stalled.
//
//   Parameters:
//      MUL_LATENCY - cycles spent in the MUL state (1..8)
//   Ports:
//      clk         - clock
//      reset       - synchronous, active-high reset
//      bus         - muldiv_unit_if.slave (request, controls, busy/done/result)
//   Configuration macro:
//      MULDIV_MADD_EN - when defined, ops 4..7 accumulate into {hi_in,lo_in};
//                       when undefined they behave as MULT/MULTU and the
//                       accumulator datapath is not built.
// ----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int MUL_LATENCY = 2
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [5:0]  cnt_q;
   logic        sgn_q;        // signed operation (even op codes)
   logic [31:0] rs_q, rt_q;
   logic [31:0] quo_q;        // dividend magnitude shifting out, quotient shifting in
   logic [31:0] rem_q;        // partial remainder
   logic [31:0] hi_q, lo_q;
`ifdef MULDIV_MADD_EN
   logic        acc_en_q;
   logic        acc_sub_q;
   logic [63:0] acc_q;
`endif

   function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
      return (sgn && x[31]) ? (~x + 32'd1) : x;
   endfunction

   logic accept;
   logic is_div_op;
   logic mul_last;
   logic div_last;

   assign accept    = (state_q == ST_IDLE) && bus.start && !bus.bubble && !bus.nullify;
   assign is_div_op = (bus.op == 3'd2) || (bus.op == 3'd3);
   assign mul_last  = (cnt_q == 6'(MUL_LATENCY - 1));
   assign div_last  = (cnt_q == 6'd31);

   // ---------------------------------------------------------------- divider
   logic [31:0] dvs_mag;
   logic [32:0] rem_sh;
   logic [32:0] rem_sub;
   logic [31:0] quo_step, rem_step;
   logic [31:0] div_hi, div_lo;

   always_comb begin
      dvs_mag = mag(rt_q, sgn_q);
      rem_sh  = {rem_q, quo_q[31]};
      rem_sub = rem_sh - {1'b0, dvs_mag};
      if (!rem_sub[32]) begin
         rem_step = rem_sub[31:0];
         quo_step = {quo_q[30:0], 1'b1};
      end else begin
         rem_step = rem_sh[31:0];
         quo_step = {quo_q[30:0], 1'b0};
      end
      // Final values use the last iteration's step directly. The magnitude
      // path already yields 0x8000_0000 / -1 = 0x8000_0000 rem 0.
      if (rt_q == 32'd0) begin
         div_lo = 32'hFFFF_FFFF;
         div_hi = rs_q;
      end else begin
         div_lo = (sgn_q && (rs_q[31] ^ rt_q[31])) ? (~quo_step + 32'd1) : quo_step;
         div_hi = (sgn_q && rs_q[31]) ? (~rem_step + 32'd1) : rem_step;
      end
   end

   // ------------------------------------------------------------- multiplier
   logic [63:0] a_ext, b_ext, prod, mul_res;

   always_comb begin
      a_ext = sgn_q ? {{32{rs_q[31]}}, rs_q} : {32'd0, rs_q};
      b_ext = sgn_q ? {{32{rt_q[31]}}, rt_q} : {32'd0, rt_q};
      // Low 64 bits of the extended product are the exact signed/unsigned result.
      prod  = a_ext * b_ext;
`ifdef MULDIV_MADD_EN
      if (acc_en_q)
         mul_res = acc_sub_q ? (acc_q - prod) : (acc_q + prod);
      else
         mul_res = prod;
`else
      mul_res = prod;
`endif
   end

   // -------------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)      state_d = is_div_op ? ST_DIV : ST_MUL;
         ST_MUL:  if (mul_last)    state_d = ST_DONE;
         ST_DIV:  if (div_last)    state_d = ST_DONE;
         ST_DONE: if (!bus.stall)  state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
      if (bus.nullify)
         state_d = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 6'd0;
         sgn_q     <= 1'b0;
         rs_q      <= 32'd0;
         rt_q      <= 32'd0;
         quo_q     <= 32'd0;
         rem_q     <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
`ifdef MULDIV_MADD_EN
         acc_en_q  <= 1'b0;
         acc_sub_q <= 1'b0;
         acc_q     <= 64'd0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q     <= 6'd0;
            sgn_q     <= ~bus.op[0];
            rs_q      <= bus.rs;
            rt_q      <= bus.rt;
            quo_q     <= mag(bus.rs, ~bus.op[0]);
            rem_q     <= 32'd0;
`ifdef MULDIV_MADD_EN
            acc_en_q  <= bus.op[2];
            acc_sub_q <= bus.op[1];
            acc_q     <= {bus.hi_in, bus.lo_in};
`endif
         end else if (state_q == ST_MUL || state_q == ST_DIV) begin
            cnt_q <= cnt_q + 6'd1;
            if (state_q == ST_DIV) begin
               quo_q <= quo_step;
               rem_q <= rem_step;
            end
         end
         // Results change only on entry to DONE; a nullify suppresses entry.
         if (state_d == ST_DONE && state_q == ST_MUL) begin
            hi_q <= mul_res[63:32];
            lo_q <= mul_res[31:0];
         end else if (state_d == ST_DONE && state_q == ST_DIV) begin
            hi_q <= div_hi;
            lo_q <= div_lo;
         end
      end
   end

   assign bus.busy   = ((state_q == ST_IDLE) && bus.start && !bus.bubble)
                       || (state_q == ST_MUL) || (state_q == ST_DIV);
   assign bus.done   = (state_q == ST_DONE);
   assign bus.hi_out = hi_q;
   assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed vectors for muldiv_unit. Stimulus pushes the expected result and
//   the cycle in which done must rise into a queue; a monitor pops and
//   compares on each rising edge of done.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;
   localparam int LAT = 2;

   logic clk;
   logic reset;
   int   cyc;
   int   tests;
   int   fails;

   muldiv_unit_if bus();

   muldiv_unit #(.MUL_LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string       nm;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] last_hi, last_lo;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // --------------------------------------------------------------- monitor
   initial begin
      logic done_d;
      exp_t e;
      done_d = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.done && !done_d) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 64'(bus.done), 64'd0);
            end else begin
               e = sb_q.pop_front();
               $display("[TB] txn %s cycle %0d hi=%h lo=%h", e.nm, cyc, bus.hi_out, bus.lo_out);
               check({e.nm, "_hi"}, 64'(bus.hi_out), 64'(e.hi));
               check({e.nm, "_lo"}, 64'(bus.lo_out), 64'(e.lo));
               check({e.nm, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
            end
         end
         done_d = bus.done;
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic push(input string nm, input logic [31:0] hi, input logic [31:0] lo, input int c);
      exp_t e;
      e.nm = nm; e.hi = hi; e.lo = lo; e.cyc = c;
      sb_q.push_back(e);
      last_hi = hi;
      last_lo = lo;
   endtask

   // Polls at negedges until done; busy must stay high until then and be low in the done cycle.
   task automatic wait_done(input string nm);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b1;
      @(negedge clk);
      while (!bus.done && n < 100) begin
         if (!bus.busy) ok = 1'b0;
         @(negedge clk);
         n++;
      end
      check({nm, "_timeout"}, 64'(n < 100), 64'd1);
      check({nm, "_busy_window"}, 64'(ok && !bus.busy), 64'd1);
   endtask

   task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] hin, input logic [31:0] lin,
                        input logic [31:0] ehi, input logic [31:0] elo, input int lat);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.bubble = 1'b0; bus.op = op;
      bus.rs = rs; bus.rt = rt; bus.hi_in = hin; bus.lo_in = lin;
      push(nm, ehi, elo, cyc + lat + 1);
      @(negedge clk);
      check({nm, "_busy_c0"}, 64'(bus.busy), 64'd1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(nm);
   endtask

   initial begin
      logic [31:0] h0, l0;
      bit          quiet;
      tests = 0; fails = 0; cyc = 0;
      reset = 1'b1;
      bus.start = 1'b0; bus.op = 3'd0; bus.rs = 32'd0; bus.rt = 32'd0;
      bus.hi_in = 32'd0; bus.lo_in = 32'd0;
      bus.stall = 1'b0; bus.bubble = 1'b0; bus.nullify = 1'b0;
      last_hi = 32'd0; last_lo = 32'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_result", {bus.hi_out, bus.lo_out}, 64'd0);

      issue("mult_m3x5",  3'd0, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT);
      issue("multu_big",  3'd1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'h0000_0001, 32'hFFFF_FFFE, LAT);
      issue("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd0, 32'd0, 32'd2, 32'd14, 32);
      issue("div_m7_2",   3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32);
      issue("div_7_m2",   3'd2, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFD, 32);
      issue("div_5_0",    3'd2, 32'd5, 32'd0, 32'd0, 32'd0, 32'd5, 32'hFFFF_FFFF, 32);
      issue("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 32);
      issue("divu_max_10",3'd3, 32'hFFFF_FFFF, 32'd10, 32'd0, 32'd0, 32'd5, 32'h1999_9999, 32);
`ifdef MULDIV_MADD_EN
      issue("madd_carry", 3'd4, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, LAT);
      issue("msub_neg",   3'd6, 32'd2, 32'd3, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
      issue("maddu_big",  3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'h0000_0001, LAT);
`else
      issue("madd_carry", 3'd4, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, LAT);
      issue("msub_neg",   3'd6, 32'd2, 32'd3, 32'd0, 32'd5, 32'd0, 32'd6, LAT);
      issue("maddu_big",  3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFE, 32'h0000_0001, LAT);
`endif

      // DIVU nullified in cycle 10: IDLE in cycle 11 with the prior result kept.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 3'd3; bus.rs = 32'd1000; bus.rt = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1 bus.nullify = 1'b1;
      @(posedge clk); #1;
      bus.nullify = 1'b0;
      @(negedge clk);
      check("nullify_busy", 64'(bus.busy), 64'd0);
      check("nullify_done", 64'(bus.done), 64'd0);
      check("nullify_result", {bus.hi_out, bus.lo_out}, {last_hi, last_lo});
      quiet = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (bus.done || bus.busy) quiet = 1'b0;
      end
      check("nullify_no_done", 64'(quiet), 64'd1);

      // Nullify beats acceptance in IDLE.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.nullify = 1'b1; bus.op = 3'd0; bus.rs = 32'd9; bus.rt = 32'd9;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.nullify = 1'b0;
      quiet = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.done || bus.busy) quiet = 1'b0;
      end
      check("nullify_over_accept", 64'(quiet), 64'd1);

      // Bubble holds off acceptance for 3 cycles; then stall holds DONE for 2 cycles.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.bubble = 1'b1; bus.op = 3'd0;
      bus.rs = 32'd6; bus.rt = 32'hFFFF_FFF9;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("bubble_busy_c%0d", k), 64'(bus.busy), 64'd0);
         @(posedge clk); #1;
      end
      bus.bubble = 1'b0;
      bus.stall  = 1'b1;
      push("mult_bubble", 32'hFFFF_FFFF, 32'hFFFF_FFD6, cyc + LAT + 1);
      @(negedge clk);
      check("bubble_accept_busy", 64'(bus.busy), 64'd1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done("mult_bubble");
      h0 = bus.hi_out; l0 = bus.lo_out;
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_hold1", {31'd0, bus.done, bus.hi_out, bus.lo_out}, {31'd0, 1'b1, h0, l0});
      @(posedge clk); #1;
      bus.stall = 1'b0;
      @(negedge clk);
      check("stall_hold2", {31'd0, bus.done, bus.hi_out, bus.lo_out}, {31'd0, 1'b1, h0, l0});
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_release", 64'({bus.done, bus.busy}), 64'd0);

      // Reset during MUL discards the operation and clears the result.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 3'd1; bus.rs = 32'd3; bus.rt = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      quiet = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (bus.done || bus.busy) quiet = 1'b0;
      end
      check("reset_mid_quiet", 64'(quiet), 64'd1);
      check("reset_mid_result", {bus.hi_out, bus.lo_out}, 64'd0);

      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
